// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for the multiplexed 7-segment scan driver: display data in, pin drives out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic                    en;
  logic                    blank_lz;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;

  modport master (
    output load, en, blank_lz, digits_in, dp_in,
    input  seg_out, dp_out, dig_sel, frame_done
  );

  modport slave (
    input  load, en, blank_lz, digits_in, dp_in,
    output seg_out, dp_out, dig_sel, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: prescaled digit scan, shadow data registers,
// hex decode with leading-zero blanking and registered, polarity-configurable pins.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_IDLE = SEG_INV ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = DIG_INV ? '1 : '0;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg);
    return seg ^ {7{SEG_INV}};
  endfunction

  function automatic logic [NUM_DIGITS-1:0] sel_polarity(input logic [NUM_DIGITS-1:0] sel);
    return sel ^ {NUM_DIGITS{DIG_INV}};
  endfunction

  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] shadow_dig_p0;
  logic [NUM_DIGITS-1:0]   shadow_dp_p0;
  logic                    tick_p0;

  logic [3:0]              nib_p0;
  logic                    dpreq_p0;
  logic                    zero_run_p0;
  logic [NUM_DIGITS-1:0]   lead_p0;
  logic [6:0]              seg_raw_p0;
  logic                    dp_raw_p0;
  logic [NUM_DIGITS-1:0]   sel_raw_p0;

  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic [NUM_DIGITS-1:0]   sel_p1;
  logic                    fd_p1;

  // ---- stage p0: prescaler, digit index, shadow data ----
  assign tick_p0 = (cnt_p0 == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0        <= '0;
      idx_p0        <= '0;
      shadow_dig_p0 <= '0;
      shadow_dp_p0  <= '0;
    end else begin
      cnt_p0 <= tick_p0 ? '0 : cnt_p0 + 1'b1;
      if (tick_p0)
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      if (bus.load) begin
        shadow_dig_p0 <= bus.digits_in;
        shadow_dp_p0  <= bus.dp_in;
      end
    end
  end

  always_comb begin
    nib_p0      = '0;
    dpreq_p0    = 1'b0;
    zero_run_p0 = 1'b1;
    lead_p0     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        nib_p0   = shadow_dig_p0[i*4 +: 4];
        dpreq_p0 = shadow_dp_p0[i];
      end
    end
    // A digit is a leading zero when it and every more-significant digit are zero;
    // digit 0 stays out of the mask so a zero value still shows "0".
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_p0 = zero_run_p0 & (shadow_dig_p0[i*4 +: 4] == 4'h0);
      lead_p0[i]  = zero_run_p0;
    end
    sel_raw_p0 = NUM_DIGITS'(1) << idx_p0;
    if (!bus.en) begin
      seg_raw_p0 = 7'h40;
      dp_raw_p0  = 1'b0;
    end else if (bus.blank_lz && lead_p0[idx_p0]) begin
      seg_raw_p0 = 7'h00;
      dp_raw_p0  = dpreq_p0;
    end else begin
      seg_raw_p0 = hex_decode(nib_p0);
      dp_raw_p0  = dpreq_p0;
    end
  end

  // ---- stage p1: registered pin drives ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1 <= SEG_IDLE;
      dp_p1  <= SEG_INV;
      sel_p1 <= SEL_IDLE;
      fd_p1  <= 1'b0;
    end else begin
      seg_p1 <= seg_polarity(seg_raw_p0);
      dp_p1  <= dp_raw_p0 ^ SEG_INV;
      sel_p1 <= sel_polarity(sel_raw_p0);
      fd_p1  <= tick_p0 && (idx_p0 == IDX_LAST);
    end
  end

  assign bus.seg_out    = seg_p1;
  assign bus.dp_out     = dp_p1;
  assign bus.dig_sel    = sel_p1;
  assign bus.frame_done = fd_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized, model-checked bench for seg7_scan_driver: one active-high and one
// active-low instance share the stimulus and are checked against the same model.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int DV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        en = 1'b1;
  logic        blank_lz = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus0();
  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus1();

  assign bus0.load = load;
  assign bus0.en = en;
  assign bus0.blank_lz = blank_lz;
  assign bus0.digits_in = digits_in;
  assign bus0.dp_in = dp_in;
  assign bus1.load = load;
  assign bus1.en = en;
  assign bus1.blank_lz = blank_lz;
  assign bus1.digits_in = digits_in;
  assign bus1.dp_in = dp_in;

  seg7_scan_driver #(.NUM_DIGITS(ND), .DIV(DV), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seg7_scan_driver #(.NUM_DIGITS(ND), .DIV(DV), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Reference model: shadow contents plus a count of clock edges since reset release.
  logic [6:0]  segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          n_edges = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_sel;
  logic        exp_fd;
  logic [6:0]  seen_seg [4];
  logic        seen_dp [4];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edges = 0;
    m_dig = '0;
    m_dp = '0;
  endtask

  task automatic model_edge();
    int d;
    int msd;
    n_edges++;
    d = ((n_edges - 1) / DV) % ND;
    exp_sel = 4'(1 << d);
    exp_fd = ((n_edges % (DV * ND)) == 0);
    msd = 0;
    for (int i = 0; i < ND; i++)
      if (m_dig[i*4 +: 4] != 4'h0) msd = i;
    if (!en) begin
      exp_seg = 7'h40;
      exp_dp = 1'b0;
    end else if (blank_lz && d > msd) begin
      exp_seg = 7'h00;
      exp_dp = m_dp[d];
    end else begin
      exp_seg = segtab[m_dig[d*4 +: 4]];
      exp_dp = m_dp[d];
    end
    if (load) begin
      m_dig = digits_in;
      m_dp = dp_in;
    end
  endtask

  task automatic compare_all();
    logic [6:0] inv_seg;
    logic [3:0] inv_sel;
    logic       inv_dp;
    inv_seg = ~exp_seg;
    inv_sel = ~exp_sel;
    inv_dp = ~exp_dp;
    check_val("seg", 16'(bus0.seg_out), 16'(exp_seg));
    check_val("dp", 16'(bus0.dp_out), 16'(exp_dp));
    check_val("dig_sel", 16'(bus0.dig_sel), 16'(exp_sel));
    check_val("frame_done", 16'(bus0.frame_done), 16'(exp_fd));
    check_val("seg_inv", 16'(bus1.seg_out), 16'(inv_seg));
    check_val("dp_inv", 16'(bus1.dp_out), 16'(inv_dp));
    check_val("dig_sel_inv", 16'(bus1.dig_sel), 16'(inv_sel));
    check_val("frame_done_inv", 16'(bus1.frame_done), 16'(exp_fd));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_seg"}, 16'(bus0.seg_out), 16'h00);
    check_val({tag, "_dp"}, 16'(bus0.dp_out), 16'h0);
    check_val({tag, "_sel"}, 16'(bus0.dig_sel), 16'h0);
    check_val({tag, "_fd"}, 16'(bus0.frame_done), 16'h0);
    check_val({tag, "_seg_inv"}, 16'(bus1.seg_out), 16'h7F);
    check_val({tag, "_dp_inv"}, 16'(bus1.dp_out), 16'h1);
    check_val({tag, "_sel_inv"}, 16'(bus1.dig_sel), 16'hF);
    check_val({tag, "_fd_inv"}, 16'(bus1.frame_done), 16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic load_data(input logic [15:0] dig, input logic [3:0] dp);
    digits_in = dig;
    dp_in = dp;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic record_frame();
    for (int s = 0; s < DV * ND; s++) begin
      step();
      for (int d = 0; d < ND; d++)
        if (bus0.dig_sel[d]) begin
          seen_seg[d] = bus0.seg_out;
          seen_dp[d] = bus0.dp_out;
        end
    end
  endtask

  initial begin
    int fd_cnt;
    int fd_first;
    int fd_last;
    int found;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // First slot after release shows zeroed shadow data on digit 0.
    step();
    check_val("first_seg", 16'(bus0.seg_out), 16'h3F);
    check_val("first_sel", 16'(bus0.dig_sel), 16'h1);

    // Basic decode, dp routing and scan order.
    load_data(16'h12A7, 4'b0100);
    record_frame();
    check_val("r31_d0", 16'(seen_seg[0]), 16'h07);
    check_val("r31_d1", 16'(seen_seg[1]), 16'h77);
    check_val("r31_d2", 16'(seen_seg[2]), 16'h5B);
    check_val("r31_d3", 16'(seen_seg[3]), 16'h06);
    check_val("r31_dp2", 16'(seen_dp[2]), 16'h1);
    check_val("r31_dp0", 16'(seen_dp[0]), 16'h0);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_data(16'h0030, 4'b0000);
    record_frame();
    check_val("lz_d3", 16'(seen_seg[3]), 16'h00);
    check_val("lz_d2", 16'(seen_seg[2]), 16'h00);
    check_val("lz_d1", 16'(seen_seg[1]), 16'h4F);
    check_val("lz_d0", 16'(seen_seg[0]), 16'h3F);
    load_data(16'h0000, 4'b1111);
    record_frame();
    check_val("lz0_d3", 16'(seen_seg[3]), 16'h00);
    check_val("lz0_d1", 16'(seen_seg[1]), 16'h00);
    check_val("lz0_d0", 16'(seen_seg[0]), 16'h3F);
    check_val("lz0_dp3", 16'(seen_dp[3]), 16'h1);
    blank_lz = 1'b0;

    // Frame pulse cadence over 48 free-running clocks.
    fd_cnt = 0;
    fd_first = -1;
    fd_last = -1;
    for (int s = 0; s < 48; s++) begin
      step();
      if (bus0.frame_done) begin
        if (fd_cnt > 0) check_val("fd_spacing", 16'(s - fd_last), 16'd16);
        if (fd_first < 0) fd_first = s;
        fd_last = s;
        fd_cnt++;
      end
    end
    check_val("fd_count", 16'(fd_cnt), 16'd3);

    // Display disabled: dashes everywhere, scan continues.
    en = 1'b0;
    record_frame();
    for (int d = 0; d < ND; d++) begin
      check_val("dash_seg", 16'(seen_seg[d]), 16'h40);
      check_val("dash_dp", 16'(seen_dp[d]), 16'h0);
    end
    en = 1'b1;

    // Reset mid-scan while digit 2 is active.
    found = 0;
    for (int s = 0; s < 2 * DV * ND && found == 0; s++) begin
      step();
      if (bus0.dig_sel == 4'b0100) found = 1;
    end
    check_val("find_d2", 16'(found), 16'd1);
    #2 rst_n = 1'b0;
    #1 check_idle("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int s = 0; s < DV; s++) begin
      step();
      check_val("rel_sel", 16'(bus0.dig_sel), 16'h1);
      check_val("rel_seg", 16'(bus0.seg_out), 16'h3F);
    end

    // Randomized traffic, including loads coinciding with ticks.
    for (int it = 0; it < 600; it++) begin
      logic [15:0] r;
      int sig;
      r = 16'($urandom);
      sig = $urandom_range(0, 4);
      for (int i = sig; i < 4; i++) r[i*4 +: 4] = 4'h0;
      digits_in = r;
      dp_in = 4'($urandom);
      load = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 7) != 0);
      blank_lz = 1'($urandom);
      step();
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DIV, default 50000: clocks per digit slot (refresh prescale); legal range 2..2^20.
REQ-003 Parameter SEG_ACTIVE_LOW, default 0: 1 inverts seg_out and dp_out (common-anode).
REQ-004 Parameter DIG_ACTIVE_LOW, default 0: 1 inverts dig_sel.
REQ-005 clk  input  1  single system clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 en  input  1  1 = show data; 0 = every digit shows dash (segment g only).
REQ-008 load  input  1  1 = capture digits_in/dp_in into shadow registers this cycle.
REQ-009 digits_in  input  4*NUM_DIGITS  hex nibbles; nibble 0 [3:0] = rightmost digit.
REQ-010 dp_in  input  NUM_DIGITS  decimal-point request per digit; bit 0 = rightmost.
REQ-011 blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-012 seg_out  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-013 dp_out  output  1  decimal point of the active digit, registered.
REQ-014 dig_sel  output  NUM_DIGITS  one-hot digit enable, registered.
REQ-015 frame_done  output  1  one-cycle pulse per completed scan of all digits, registered.

Function
REQ-016 Prescaler SHALL count 0..DIV-1 and wrap; tick asserted when count = DIV-1.
REQ-017 Digit index SHALL advance by 1 on each tick, wrapping NUM_DIGITS-1 -> 0; NUM_DIGITS=1 holds index at 0.
REQ-018 frame_done SHALL pulse high for exactly one clock, in the cycle after the tick that wraps the index to 0.
REQ-019 On load=1, the shadow registers SHALL capture digits_in and dp_in at that edge; seg_out reflects the new data one clock later; the index and prescaler are unaffected.
REQ-020 Outputs SHALL be registered from the current index and shadow state: 1-clock latency from an index change or shadow update to the pins.
REQ-021 dig_sel SHALL be one-hot at the active index (before polarity inversion), including when en=0.
REQ-022 Decode (active-high, before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-023 en=0: seg_out SHALL be 0x40 (dash) and dp_out 0 for every digit; scanning continues.
REQ-024 blank_lz=1: zero digits from the most significant digit downward, up to the first non-zero digit, SHALL drive seg_out 0x00; digit 0 is never blanked; dp_out still follows dp_in.
REQ-025 blank_lz=0: no digit is blanked.
REQ-026 Polarity parameters SHALL apply only at the output registers, after all decode and blanking logic.
REQ-027 load and tick in the same cycle SHALL both take effect; the newly indexed digit shows the new data.

Reset
REQ-028 rst_n=0 SHALL immediately clear prescaler, index and shadow registers to 0 and drive seg_out, dp_out and dig_sel to their inactive level (0x00/0/all-off after polarity) and frame_done to 0.
REQ-029 Reset asserted mid-scan SHALL abandon the frame; after release, scanning restarts at digit 0 with a full DIV-clock slot and no frame_done until a full frame completes.
REQ-030 The first clock after release SHALL show digit 0 from zeroed shadow data (0x3F with blank_lz=0).

Verification (NUM_DIGITS=4, DIV=4, polarities 0)
REQ-031 Load 0x12A7, dp_in=0b0100, en=1, blank_lz=0 -> dig_sel 0001,0010,0100,1000 for 4 clocks each; seg_out 07,77,5B,06; dp_out=1 only while dig_sel=0100.
REQ-032 Load 0x0030, blank_lz=1 -> digit3=00, digit2=00, digit1=4F, digit0=3F; load 0x0000 -> only digit0 shows 3F.
REQ-033 Free-run 48 clocks -> frame_done pulses exactly 3 times, 16 clocks apart, each 1 clock wide, in the cycle after the 3->0 wrap.
REQ-034 en=0 for a full frame -> seg_out=40, dp_out=0 on all four digits; dig_sel keeps rotating.
REQ-035 Assert rst_n=0 while dig_sel=0100 -> outputs inactive immediately, without a clock; after release, dig_sel=0001 for 4 clocks with seg_out=3F.
REQ-036 Rerun REQ-031 with SEG_ACTIVE_LOW=1 and DIG_ACTIVE_LOW=1 -> all outputs bitwise inverted; reset levels 0x7F, dp_out=1, dig_sel=1111.
